// File: rtl/jtframe_sim_inputs.sv
// ============================================================================
//  Module   : jtframe_sim_inputs
//  Brief    : Frame-scripted player-1 stimulus (coin, start, joystick walk)
//             for unattended simulation of a game core. Outputs active-low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_sim_inputs #(
   parameter int unsigned COIN_FRAME  = 16,
   parameter int unsigned START_FRAME = 32,
   parameter int unsigned PULSE       = 4,
   parameter int unsigned PLAY_FRAME  = 48,
   parameter int unsigned STEP        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       loop_rst,
   input  logic       LVBL,
   output logic [6:0] game_joystick1,
   output logic       button_1p,
   output logic       coin_left
);

   // Windows are compared in 17 bits so a window ending past 16'hFFFF cannot wrap
   localparam logic [16:0] c_coin_lo  = 17'(COIN_FRAME);
   localparam logic [16:0] c_coin_hi  = 17'(COIN_FRAME + PULSE);
   localparam logic [16:0] c_start_lo = 17'(START_FRAME);
   localparam logic [16:0] c_start_hi = 17'(START_FRAME + PULSE);
   localparam logic [16:0] c_play     = 17'(PLAY_FRAME);
   localparam logic [7:0]  c_step_max = 8'(STEP - 1);

   logic        lvbl_l_q,    lvbl_l_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]  step_cnt_q,  step_cnt_d;
   logic [2:0]  pat_idx_q,   pat_idx_d;
   logic [6:0]  joy_q,       joy_d;
   logic        start_q,     start_d;
   logic        coin_q,      coin_d;

   logic        tick;
   logic [15:0] f_next;
   logic [16:0] f_ext;
   logic [6:0]  pattern;

   always_comb begin
      case (pat_idx_q)
         3'd0:    pattern = 7'h7E;
         3'd1:    pattern = 7'h7D;
         3'd2:    pattern = 7'h7B;
         3'd3:    pattern = 7'h77;
         3'd4:    pattern = 7'h6F;
         3'd5:    pattern = 7'h5F;
         3'd6:    pattern = 7'h3F;
         default: pattern = 7'h7F;
      endcase
   end

   always_comb begin
      tick        = lvbl_l_q & ~LVBL;
      f_next      = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
      f_ext       = {1'b0, f_next};

      lvbl_l_d    = LVBL;
      frame_cnt_d = frame_cnt_q;
      step_cnt_d  = step_cnt_q;
      pat_idx_d   = pat_idx_q;
      joy_d       = joy_q;
      start_d     = start_q;
      coin_d      = coin_q;

      if (loop_rst) begin
         frame_cnt_d = 16'd0;
         step_cnt_d  = 8'd0;
         pat_idx_d   = 3'd0;
         joy_d       = 7'h7F;
         start_d     = 1'b1;
         coin_d      = 1'b1;
      end else if (tick) begin
         frame_cnt_d = f_next;
         coin_d      = ~((f_ext >= c_coin_lo)  && (f_ext < c_coin_hi));
         start_d     = ~((f_ext >= c_start_lo) && (f_ext < c_start_hi));
         if (f_ext < c_play) begin
            joy_d = 7'h7F;
         end else begin
            // Show the current step's pattern, then advance toward the next one
            joy_d = pattern;
            if (step_cnt_q == c_step_max) begin
               step_cnt_d = 8'd0;
               pat_idx_d  = pat_idx_q + 3'd1;
            end else begin
               step_cnt_d = step_cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvbl_l_q    <= 1'b1;
         frame_cnt_q <= 16'd0;
         step_cnt_q  <= 8'd0;
         pat_idx_q   <= 3'd0;
         joy_q       <= 7'h7F;
         start_q     <= 1'b1;
         coin_q      <= 1'b1;
      end else begin
         lvbl_l_q    <= lvbl_l_d;
         frame_cnt_q <= frame_cnt_d;
         step_cnt_q  <= step_cnt_d;
         pat_idx_q   <= pat_idx_d;
         joy_q       <= joy_d;
         start_q     <= start_d;
         coin_q      <= coin_d;
      end
   end

   assign game_joystick1 = joy_q;
   assign button_1p      = start_q;
   assign coin_left      = coin_q;

endmodule

`default_nettype wire

// File: tb/tb_jtframe_sim_inputs.sv
// ============================================================================
//  Module   : tb_jtframe_sim_inputs
//  Brief    : Bench for jtframe_sim_inputs: frame-level model plus directed
//             frame sequences with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtframe_sim_inputs;

   localparam int COIN_FRAME  = 16;
   localparam int START_FRAME = 32;
   localparam int PULSE       = 4;
   localparam int PLAY_FRAME  = 48;
   localparam int STEP        = 8;

   logic       clk;
   logic       rst_n;
   logic       loop_rst;
   logic       LVBL;
   logic [6:0] game_joystick1;
   logic       button_1p;
   logic       coin_left;

   int n_tests = 0;
   int n_fail  = 0;

   jtframe_sim_inputs #(
      .COIN_FRAME  (COIN_FRAME),
      .START_FRAME (START_FRAME),
      .PULSE       (PULSE),
      .PLAY_FRAME  (PLAY_FRAME),
      .STEP        (STEP)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .loop_rst       (loop_rst),
      .LVBL           (LVBL),
      .game_joystick1 (game_joystick1),
      .button_1p      (button_1p),
      .coin_left      (coin_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: the frame number alone determines every output
   logic        m_prev;
   logic [15:0] m_f;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prev <= 1'b1;
         m_f    <= 16'd0;
      end else begin
         m_prev <= LVBL;
         if (loop_rst)
            m_f <= 16'd0;
         else if (m_prev && !LVBL && m_f != 16'hFFFF)
            m_f <= m_f + 16'd1;
      end
   end

   function automatic logic [6:0] model_joy(input logic [15:0] f);
      int idx;
      if (int'(f) < PLAY_FRAME) return 7'h7F;
      idx = ((int'(f) - PLAY_FRAME) / STEP) % 8;
      if (idx == 7) return 7'h7F;
      return ~(7'(1) << idx);
   endfunction

   function automatic logic model_low(input logic [15:0] f, input int lo);
      return (int'(f) >= lo) && (int'(f) < lo + PULSE);
   endfunction

   always @(negedge clk) begin
      chk("joy_model",   {9'd0, game_joystick1}, {9'd0, model_joy(m_f)});
      chk("start_model", {15'd0, button_1p},     {15'd0, ~model_low(m_f, START_FRAME)});
      chk("coin_model",  {15'd0, coin_left},     {15'd0, ~model_low(m_f, COIN_FRAME)});
   end

   task automatic step_clk();
      @(posedge clk);
      #2;
   endtask

   task automatic frame();
      LVBL = 1'b1;
      repeat (3) step_clk();
      LVBL = 1'b0;
      repeat (3) step_clk();
   endtask

   task automatic chk_outs(input string name, input logic [6:0] joy, input logic st, input logic cn);
      chk({name, "_joy"},   {9'd0, game_joystick1}, {9'd0, joy});
      chk({name, "_start"}, {15'd0, button_1p},     {15'd0, st});
      chk({name, "_coin"},  {15'd0, coin_left},     {15'd0, cn});
   endtask

   initial begin
      rst_n    = 1'b0;
      loop_rst = 1'b0;
      LVBL     = 1'b1;
      repeat (3) step_clk();
      chk_outs("reset", 7'h7F, 1'b1, 1'b1);
      chk("reset_frame", dut.frame_cnt_q, 16'd0);
      rst_n = 1'b1;
      frame();
      frame();
      chk("two_frames", dut.frame_cnt_q, 16'd2);

      // Asynchronous reset mid-frame
      LVBL = 1'b1;
      step_clk();
      rst_n = 1'b0;
      #1;
      chk_outs("async_rst", 7'h7F, 1'b1, 1'b1);
      chk("async_rst_frame", dut.frame_cnt_q, 16'd0);
      step_clk();
      rst_n = 1'b1;
      step_clk();
      LVBL = 1'b0;
      repeat (2) step_clk();
      chk("first_fall", dut.frame_cnt_q, 16'd1);

      for (int k = 2; k <= 120; k++) begin
         frame();
         case (k)
            15:  chk_outs("f15",  7'h7F, 1'b1, 1'b1);
            16:  chk_outs("f16",  7'h7F, 1'b1, 1'b0);
            19:  chk_outs("f19",  7'h7F, 1'b1, 1'b0);
            20:  chk_outs("f20",  7'h7F, 1'b1, 1'b1);
            32:  chk_outs("f32",  7'h7F, 1'b0, 1'b1);
            35:  chk_outs("f35",  7'h7F, 1'b0, 1'b1);
            36:  chk_outs("f36",  7'h7F, 1'b1, 1'b1);
            47:  chk_outs("f47",  7'h7F, 1'b1, 1'b1);
            48:  chk_outs("f48",  7'h7E, 1'b1, 1'b1);
            55:  chk_outs("f55",  7'h7E, 1'b1, 1'b1);
            56:  chk_outs("f56",  7'h7D, 1'b1, 1'b1);
            64:  chk_outs("f64",  7'h7B, 1'b1, 1'b1);
            72:  chk_outs("f72",  7'h77, 1'b1, 1'b1);
            80:  chk_outs("f80",  7'h6F, 1'b1, 1'b1);
            88:  chk_outs("f88",  7'h5F, 1'b1, 1'b1);
            96:  chk_outs("f96",  7'h3F, 1'b1, 1'b1);
            104: chk_outs("f104", 7'h7F, 1'b1, 1'b1);
            111: chk_outs("f111", 7'h7F, 1'b1, 1'b1);
            112: chk_outs("f112", 7'h7E, 1'b1, 1'b1);
            120: chk_outs("f120", 7'h7D, 1'b1, 1'b1);
            default: ;
         endcase
      end
      chk("frame_120", dut.frame_cnt_q, 16'd120);

      // loop_rst coincides with an LVBL fall: restart wins over the tick
      LVBL     = 1'b1;
      step_clk();
      LVBL     = 1'b0;
      loop_rst = 1'b1;
      step_clk();
      chk_outs("loop_rst", 7'h7F, 1'b1, 1'b1);
      chk("loop_rst_frame", dut.frame_cnt_q, 16'd0);
      repeat (2) step_clk();
      loop_rst = 1'b0;
      repeat (2) step_clk();
      chk("loop_rel_frame", dut.frame_cnt_q, 16'd0);
      for (int k = 1; k <= 16; k++) begin
         frame();
         if (k == 15) chk_outs("rl15", 7'h7F, 1'b1, 1'b1);
         if (k == 16) chk_outs("rl16", 7'h7F, 1'b1, 1'b0);
      end

      // LVBL held low for a long time yields a single tick
      LVBL = 1'b1;
      step_clk();
      LVBL = 1'b0;
      repeat (1000) step_clk();
      chk("hold_low", dut.frame_cnt_q, 16'd17);
      LVBL = 1'b1;
      repeat (2) step_clk();
      chk("hold_rise", dut.frame_cnt_q, 16'd17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
